// File: rtl/prach_pkg.sv
// Shared PRACH constants: eAxC RTC ID lookup indexed by [cc][ant].
// Row 3 (cc==3) is unused by hardware and kept only so a 2-bit cc indexes the table cleanly.
package prach_pkg;

  localparam logic [15:0] PrachRtcId [4][8] = '{
    '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0100, 16'h0101, 16'h0102, 16'h0103},
    '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0110, 16'h0111, 16'h0112, 16'h0113},
    '{16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0120, 16'h0121, 16'h0122, 16'h0123},
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}
  };

endpackage

// File: rtl/prach_packetizer.sv
// PRACH packetizer: prepends an eAxC header beat (RTC ID + sequence ID) to each packet.
// Optional payload length check is enabled by defining PRACH_PKT_LEN_CHECK_EN.
//
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on
// ready, and a presented master beat (m_tdata/m_tlast) stays frozen until it transfers.
module prach_packetizer
  import prach_pkg::*;
#(
  parameter int PKT_LEN = 864
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_tdata,
  input  logic [4:0]  s_tuser,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        err_id,
  output logic        err_len,
  output logic [1:0]  stateDbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } stateT;

  stateT       state;
  logic [1:0]  cc;
  logic [2:0]  ant;
  logic [7:0]  seq [24];
  logic        outFree;
  logic [4:0]  curId;

  if (PKT_LEN < 1 || PKT_LEN > 1023) begin : gPktLenRange
    $error("prach_packetizer: PKT_LEN must be in 1..1023");
  end

  // The output register can take a new beat when empty or when its beat leaves this edge.
  assign outFree  = !m_tvalid || m_tready;
  assign curId    = {cc, ant};
  assign s_tready = (state == DROP) || ((state == PAYLOAD) && outFree);
  assign stateDbg = state;

`ifdef PRACH_PKT_LEN_CHECK_EN
  localparam logic [9:0] PktLen = 10'(PKT_LEN);
  logic [9:0] beatCnt;
  logic [9:0] beatNext;
  logic       lenHit;

  assign beatNext = beatCnt + 10'd1;
  assign lenHit   = (beatNext == PktLen);
`else
  assign err_len = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      err_id   <= 1'b0;
      cc       <= '0;
      ant      <= '0;
      for (int i = 0; i < 24; i++) seq[i] <= '0;
`ifdef PRACH_PKT_LEN_CHECK_EN
      err_len  <= 1'b0;
      beatCnt  <= '0;
`endif
    end else begin
      err_id <= 1'b0;
`ifdef PRACH_PKT_LEN_CHECK_EN
      err_len <= 1'b0;
`endif
      if (m_tready) m_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          // The first payload beat stays on the input; PAYLOAD consumes it next.
          if (s_tvalid) begin
            if (s_tuser[4:3] == 2'd3) begin
              err_id <= 1'b1;
              state  <= DROP;
            end else if (outFree) begin
              m_tvalid <= 1'b1;
              m_tlast  <= 1'b0;
              m_tdata  <= {PrachRtcId[s_tuser[4:3]][s_tuser[2:0]], seq[s_tuser], 8'h00};
              cc       <= s_tuser[4:3];
              ant      <= s_tuser[2:0];
              state    <= PAYLOAD;
`ifdef PRACH_PKT_LEN_CHECK_EN
              beatCnt  <= '0;
`endif
            end
          end
        end

        PAYLOAD: begin
          if (s_tvalid && outFree) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata;
            m_tlast  <= s_tlast;
`ifdef PRACH_PKT_LEN_CHECK_EN
            beatCnt  <= beatNext;
            if (s_tlast) begin
              seq[curId] <= seq[curId] + 8'd1;
              state      <= IDLE;
              if (!lenHit) err_len <= 1'b1;
            end else if (lenHit) begin
              // Overlong packet: close it here and swallow the rest up to s_tlast.
              m_tlast    <= 1'b1;
              err_len    <= 1'b1;
              seq[curId] <= seq[curId] + 8'd1;
              state      <= DROP;
            end
`else
            if (s_tlast) begin
              seq[curId] <= seq[curId] + 8'd1;
              state      <= IDLE;
            end
`endif
          end
        end

        DROP: begin
          if (s_tvalid && s_tlast) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prach_packetizer.sv
// Directed bench for prach_packetizer: scoreboard of expected output beats, linear steps.
// Define PRACH_PKT_LEN_CHECK_EN at build time to exercise the length check with PKT_LEN=4.
module tb_prach_packetizer;

`ifdef PRACH_PKT_LEN_CHECK_EN
  localparam int PktLen = 4;
  localparam bit LenChk = 1'b1;
`else
  localparam int PktLen = 864;
  localparam bit LenChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [4:0]  s_tuser = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        err_id;
  logic        err_len;
  logic [1:0]  stateDbg;

  prach_packetizer #(.PKT_LEN(PktLen)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .err_id(err_id), .err_len(err_len), .stateDbg(stateDbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];
  logic [7:0]  seqModel [24];
  int checks = 0;
  int errors = 0;
  int errIdSeen = 0, errLenSeen = 0, errIdExp = 0, errLenExp = 0;
  bit rdyRandom = 1'b0;
  bit rdyHold = 1'b0;
  bit prevStall = 1'b0;
  logic [32:0] prevOut = '0;
  logic [32:0] expBeat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rtcModel(input logic [1:0] cc, input logic [2:0] ant);
    return {7'b0, ant[2], 2'b0, cc, 2'b0, ant[1:0]};
  endfunction

  // Downstream ready, changed once per cycle shortly after the falling edge.
  initial forever begin
    @(negedge clk);
    #1;
    m_tready = rdyHold ? 1'b0 : (rdyRandom ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Output monitor: beats compared in order, held beats must not move.
  initial forever begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        check("stall_valid", 64'(m_tvalid), 64'd1);
        check("stall_hold", 64'({m_tlast, m_tdata}), 64'(prevOut));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'(exp_q.size()), 64'd1);
        else begin
          expBeat = exp_q.pop_front();
          check("out_beat", 64'({m_tlast, m_tdata}), 64'(expBeat));
        end
      end
      prevStall = m_tvalid && !m_tready;
      prevOut   = {m_tlast, m_tdata};
      if (err_id)  errIdSeen++;
      if (err_len) errLenSeen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pkt(input logic [1:0] cc, input logic [2:0] ant, input int n,
                          input logic [31:0] base, input bit withLast, input logic [31:0] hdr);
    int nOut;
    bit forced;
    int stall;
    logic [4:0] idx;
    logic [31:0] d;
    idx = {cc, ant};
    if (cc == 2'd3) errIdExp++;
    else begin
      forced = LenChk && (n >= PktLen) && !(withLast && n == PktLen);
      nOut = forced ? PktLen : n;
      exp_q.push_back({1'b0, hdr});
      for (int i = 0; i < nOut; i++) begin
        d = base + 32'(i);
        exp_q.push_back({(forced || withLast) && (i == nOut - 1), d});
      end
      if (forced || (LenChk && withLast && n < PktLen)) errLenExp++;
      if (forced || withLast) seqModel[idx] = seqModel[idx] + 8'd1;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tuser  = idx;
      s_tdata  = base + 32'(i);
      s_tlast  = withLast && (i == n - 1);
      #2;
      stall = 0;
      while (!s_tready && stall < 200) begin
        @(negedge clk);
        #2;
        stall++;
      end
      if (!s_tready) begin
        check("in_accept_timeout", 64'(s_tready), 64'd1);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  int e0;
  logic [1:0] rc;
  logic [2:0] ra;
  int rn;

  initial begin
    for (int i = 0; i < 24; i++) seqModel[i] = '0;

    #2;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_err_id", 64'(err_id), 64'd0);
    check("rst_err_len", 64'(err_len), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_state", 64'(stateDbg), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-length packet, then second packet on the same eAxC and one on eAxC 0.
    send_pkt(2'd1, 3'd5, 864, 32'h1000_0000, 1'b1, 32'h0111_0000);
    send_pkt(2'd1, 3'd5, 3, 32'h2000_0000, 1'b1, 32'h0111_0100);
    send_pkt(2'd0, 3'd0, 1, 32'h3000_0000, 1'b1, 32'h0000_0000);
    drain("drain_basic");

    // Header latency, driven by hand: header must be presented one cycle after s_tvalid.
    exp_q.push_back({1'b0, 32'h0002_0000});
    exp_q.push_back({1'b1, 32'hABCD_0001});
    seqModel[2] = seqModel[2] + 8'd1;
    if (LenChk) errLenExp++;
    @(negedge clk);
    s_tvalid = 1'b1; s_tuser = 5'b00_010; s_tdata = 32'hABCD_0001; s_tlast = 1'b1;
    #2;
    check("idle_holds_first_beat", 64'(s_tready), 64'd0);
    @(negedge clk);
    check("hdr_latency_valid", 64'(m_tvalid), 64'd1);
    check("hdr_latency_data", 64'(m_tdata), 64'h0002_0000);
    check("hdr_latency_last", 64'(m_tlast), 64'd0);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    drain("drain_latency");

    // cc==3 packet is dropped with one err_id pulse; next packet unaffected.
    send_pkt(2'd3, 3'd1, 2, 32'h4000_0000, 1'b1, 32'h0);
    send_pkt(2'd0, 3'd4, 2, 32'h5000_0000, 1'b1, 32'h0100_0000);
    drain("drain_bad_cc");
    check("err_id_once", 64'(errIdSeen), 64'd1);

    // 257 packets on cc=2/ant=7: sequence IDs 0..255 then wrap to 0.
    for (int k = 0; k < 257; k++) begin
      send_pkt(2'd2, 3'd7, 2, 32'h6000_0000 + 32'(k * 16), 1'b1,
               {16'h0123, 8'(k), 8'h00});
    end
    drain("drain_wrap");

    // Length check vectors (plain pass-through without the check built in).
    e0 = errLenSeen;
    send_pkt(2'd0, 3'd1, 3, 32'h7000_0000, 1'b1, 32'h0001_0000);
    drain("drain_short");
    check("err_len_short", 64'(errLenSeen - e0), LenChk ? 64'd1 : 64'd0);
    e0 = errLenSeen;
    send_pkt(2'd0, 3'd1, 6, 32'h7100_0000, 1'b1, 32'h0001_0100);
    drain("drain_long");
    check("err_len_long", 64'(errLenSeen - e0), LenChk ? 64'd1 : 64'd0);

    // Random backpressure with mixed eAxCs and occasional invalid cc.
    rdyRandom = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rc = ($urandom_range(0, 4) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ra = 3'($urandom_range(0, 7));
      rn = $urandom_range(1, 12);
      send_pkt(rc, ra, rn, 32'h8000_0000 + 32'(k * 256), 1'b1,
               {rtcModel(rc, ra), seqModel[{rc, ra}], 8'h00});
    end
    drain("drain_random");
    rdyRandom = 1'b0;
    repeat (2) @(negedge clk);

    check("err_id_total", 64'(errIdSeen), 64'(errIdExp));
    check("err_len_total", 64'(errLenSeen), 64'(errLenExp));

    // Reset mid-packet while a payload beat sits stalled in the output register.
    send_pkt(2'd1, 3'd5, 3, 32'h9000_0000, 1'b0, {rtcModel(2'd1, 3'd5), seqModel[13], 8'h00});
    rdyHold = 1'b1;
    #2;
    check("pre_reset_pending", 64'(m_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("mid_rst_m_tdata", 64'(m_tdata), 64'd0);
    check("mid_rst_s_tready", 64'(s_tready), 64'd0);
    check("mid_rst_state", 64'(stateDbg), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 24; i++) seqModel[i] = '0;
    rdyHold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_pkt(2'd1, 3'd5, 2, 32'hA000_0000, 1'b1, 32'h0111_0000);
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
